// File: rtl/seq_add_pkg.sv
// Shared definitions for the sequential multi-byte adder controller.
//   LEN_W_DEFAULT : default width of the len field
//   state_t       : controller FSM state encoding
package seq_add_pkg;

    localparam int LEN_W_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder8.sv
// 8-bit adder with carry, purely combinational.
//   a, b : operand bytes
//   cin  : carry in
//   s    : sum byte
//   cout : carry out
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

// File: rtl/seq_add_ctrl.sv
// Sequential multi-byte adder controller. Accepts len+1 operand byte pairs,
// LSB first, adds them with a rippling carry and streams out one sum byte
// per accepted pair, one cycle after acceptance.
//   clk, rst              : clock, asynchronous active-high reset
//   start, len, carry_in  : operation request (honoured only in IDLE)
//   in_valid/in_ready, a, b        : operand byte stream
//   out_valid/out_ready, sum, last : result byte stream
//   carry_out             : final carry of the last completed operation
//   busy, done            : not-IDLE flag, one-cycle completion pulse
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sum,
    output logic             last,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;

    logic [LEN_W-1:0] len_q;
    // One extra bit so len = 2^LEN_W-1 can count past the final pair without wrapping.
    logic [LEN_W:0]   cnt;
    logic             carry_q;
    logic [7:0]       sum_p1;
    logic             last_p1;
    logic             vld_p1;
    logic             carry_out_q;

    logic [7:0]       add_s;
    logic             add_c;
    logic             accept;
    logic             out_hs;
    logic             pairs_left;

    adder8 u_adder8 (
        .a    (a),
        .b    (b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_c)
    );

    assign pairs_left = (cnt <= {1'b0, len_q});
    // Ready only when the output slot is free or being drained this cycle,
    // which lets handshake and acceptance overlap for one byte per cycle.
    assign in_ready   = (state == ST_RUN) && pairs_left && (!vld_p1 || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_hs     = vld_p1 && out_ready;

    assign out_valid  = vld_p1;
    assign sum        = sum_p1;
    assign last       = last_p1;
    assign carry_out  = carry_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (out_hs && last_p1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stage p0 -> p1: operand pair accepted, sum/last registered for output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            cnt         <= '0;
            carry_q     <= 1'b0;
            sum_p1      <= '0;
            last_p1     <= 1'b0;
            vld_p1      <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                len_q       <= len;
                carry_q     <= carry_in;
                cnt         <= '0;
                carry_out_q <= 1'b0;
            end

            if (accept) begin
                sum_p1  <= add_s;
                carry_q <= add_c;
                vld_p1  <= 1'b1;
                last_p1 <= (cnt == {1'b0, len_q});
                cnt     <= cnt + {{LEN_W{1'b0}}, 1'b1};
            end else if (out_hs) begin
                vld_p1 <= 1'b0;
            end

            if (state == ST_RUN && out_hs && last_p1) begin
                carry_out_q <= carry_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_add_ctrl.sv
module tb_seq_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] len;
    logic       carry_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       last;
    logic       carry_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    seq_add_ctrl #(.LEN_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .carry_in  (carry_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .last      (last),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 3'd0;
        carry_in  = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b0;
        #2;
        // Reset state, checked before any clock edge (asynchronous reset)
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_carry_out", carry_out, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_last", last, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // in_valid in IDLE without start is ignored
        in_valid = 1'b1;
        a = 8'h55;
        b = 8'h11;
        #1;
        chk("idle_in_ready", in_ready, 0);
        tick();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Single pair: 0x7F + 0x01 + 0 = 0x80
        start = 1'b1;
        len = 3'd0;
        carry_in = 1'b0;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        in_valid = 1'b1;
        a = 8'h7F;
        b = 8'h01;
        #1;
        chk("t1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_sum", sum, 8'h80);
        chk("t1_last", last, 1);
        chk("t1_in_ready_after_last", in_ready, 0);
        chk("t1_done_early", done, 0);
        out_ready = 1'b1;
        tick();
        chk("t1_done", done, 1);
        chk("t1_carry_out", carry_out, 0);
        chk("t1_out_valid_clr", out_valid, 0);
        tick();
        chk("t1_done_clr", done, 0);
        chk("t1_idle", busy, 0);
        out_ready = 1'b0;

        // Eight pairs 0xFF+0x00 with carry_in=1: all sums 0x00, carry ripples out
        start = 1'b1;
        len = 3'd7;
        carry_in = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t3_in_ready_%0d", i), in_ready, 1);
            @(posedge clk);
            #0;
            #1;
            chk($sformatf("t3_valid_%0d", i), out_valid, 1);
            chk($sformatf("t3_sum_%0d", i), sum, 8'h00);
            chk($sformatf("t3_last_%0d", i), last, (i == 7) ? 1 : 0);
        end
        chk("t3_no_accept_after_last", in_ready, 0);
        in_valid = 1'b0;
        tick();
        chk("t3_done", done, 1);
        chk("t3_carry_out", carry_out, 1);
        chk("t3_out_valid_clr", out_valid, 0);
        tick();
        chk("t3_idle", busy, 0);
        chk("t3_carry_out_hold", carry_out, 1);

        // Two pairs with carry_in=1: 0xFF+0x00+1 = 0x00 c1, 0x01+0x02+1 = 0x04 c0
        start = 1'b1;
        len = 3'd1;
        carry_in = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_carry_out_cleared", carry_out, 0);
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        tick();
        chk("t2_sum0", sum, 8'h00);
        chk("t2_last0", last, 0);
        a = 8'h01;
        b = 8'h02;
        tick();
        in_valid = 1'b0;
        chk("t2_valid1", out_valid, 1);
        chk("t2_sum1", sum, 8'h04);
        chk("t2_last1", last, 1);
        tick();
        chk("t2_done", done, 1);
        chk("t2_carry_out", carry_out, 0);
        tick();

        // Output stall for three cycles mid-stream
        start = 1'b1;
        len = 3'd3;
        carry_in = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        a = 8'h10;
        b = 8'h01;
        tick();
        chk("t4_sum0", sum, 8'h11);
        a = 8'h20;
        b = 8'h02;
        tick();
        chk("t4_sum1", sum, 8'h22);
        out_ready = 1'b0;
        a = 8'h30;
        b = 8'h03;
        #1;
        chk("t4_stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_stall_valid_%0d", i), out_valid, 1);
            chk($sformatf("t4_stall_sum_%0d", i), sum, 8'h22);
            chk($sformatf("t4_stall_last_%0d", i), last, 0);
            chk($sformatf("t4_stall_ready_%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_resume_in_ready", in_ready, 1);
        tick();
        chk("t4_sum2", sum, 8'h33);
        chk("t4_last2", last, 0);
        a = 8'h40;
        b = 8'h04;
        tick();
        in_valid = 1'b0;
        chk("t4_sum3", sum, 8'h44);
        chk("t4_last3", last, 1);
        tick();
        chk("t4_done", done, 1);
        tick();
        out_ready = 1'b0;

        // start during RUN ignored, then reset mid-stream
        start = 1'b1;
        len = 3'd3;
        carry_in = 1'b1;
        tick();
        len = 3'd0;
        carry_in = 1'b0;
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'h01;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        chk("t5_sum_keeps_carry", sum, 8'h01);
        chk("t5_last_keeps_len", last, 0);
        chk("t5_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_carry_out", carry_out, 0);
        chk("t5_rst_sum", sum, 0);
        tick();
        rst = 1'b0;
        chk("t5_rst_done", done, 0);
        tick();
        chk("t5_post_done", done, 0);
        chk("t5_post_busy", busy, 0);
        chk("t5_post_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
